// File: rtl/riscv_wb_scoreboard.sv
// Writeback stage with load scoreboard.
// Port A carries registered EX results. Port B carries in-order load data.
// Outstanding loads are tracked two ways:
//  - a small in-order FIFO holds the destination register of each load;
//  - a per-register busy bitmap is used for hazard detection and stalls.
module riscv_wb_scoreboard #(
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_load_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_load_rd_i,
    output logic                  issue_load_ready_o,
    input  logic                  lsu_rvalid_i,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  ex_ready_o,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  hazard_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    output logic                  spurious_rvalid_o
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam int PW    = $clog2(MAX_OUTSTANDING);
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Destination-register FIFO. The storage is not reset; entries are only
    // read while the count says they are valid.
    logic [ADDR_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;

    logic [NREGS-1:0]      busy_reg;
    logic [NREGS-1:0]      busy_next;

    logic [ADDR_WIDTH-1:0] waddr_a_reg;
    logic [DATA_WIDTH-1:0] wdata_a_reg;
    logic                  we_a_reg;
    logic [ADDR_WIDTH-1:0] waddr_b_reg;
    logic [DATA_WIDTH-1:0] wdata_b_reg;
    logic                  we_b_reg;
    logic                  spurious_reg;

    logic                  load_accept;
    logic                  ex_accept;
    logic                  pop;
    logic                  spurious;
    logic [ADDR_WIDTH-1:0] head_rd;

    // Handshakes look only at registered state. A pop in the same cycle
    // does not free a slot.
    assign issue_load_ready_o = (count_reg < MAX_CNT) &&
                                !(busy_reg[issue_load_rd_i] && (issue_load_rd_i != '0));
    assign ex_ready_o         = !(busy_reg[ex_rd_i] && (ex_rd_i != '0));
    assign hazard_o           = (busy_reg[raddr_a_i] && (raddr_a_i != '0)) ||
                                (busy_reg[raddr_b_i] && (raddr_b_i != '0)) ||
                                (busy_reg[raddr_c_i] && (raddr_c_i != '0));

    assign load_accept = issue_load_valid_i && issue_load_ready_o;
    assign ex_accept   = ex_valid_i && ex_ready_o;
    assign pop         = lsu_rvalid_i && (count_reg != '0);
    assign spurious    = lsu_rvalid_i && (count_reg == '0);
    assign head_rd     = fifo_mem[rd_ptr_reg];

    // Busy bit per register. The bit clears as the port-B write commits,
    // and a newly accepted load to the same register overrides that clear.
    // x0 is never busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            assign busy_next[gi] = (gi != 0) &&
                ((busy_reg[gi] && !(we_b_reg && (waddr_b_reg == ADDR_WIDTH'(gi)))) ||
                 (load_accept && (issue_load_rd_i == ADDR_WIDTH'(gi))));
        end
    endgenerate

    // Occupancy: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        case ({load_accept, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO storage write. Load destinations are recorded in issue order.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            fifo_mem[wr_ptr_reg] <= issue_load_rd_i;
        end
    end

    // Scoreboard state and registered write ports. Reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            busy_reg     <= '0;
            waddr_a_reg  <= '0;
            wdata_a_reg  <= '0;
            we_a_reg     <= 1'b0;
            waddr_b_reg  <= '0;
            wdata_b_reg  <= '0;
            we_b_reg     <= 1'b0;
            spurious_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            busy_reg     <= busy_next;
            spurious_reg <= spurious;
            if (load_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            // Load data: one cycle after the response, in issue order.
            we_b_reg <= 1'b0;
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                we_b_reg    <= (head_rd != '0);
                waddr_b_reg <= head_rd;
                wdata_b_reg <= lsu_rdata_i;
            end
            // EX result: one cycle after acceptance.
            we_a_reg <= 1'b0;
            if (ex_accept) begin
                we_a_reg    <= (ex_rd_i != '0);
                waddr_a_reg <= ex_rd_i;
                wdata_a_reg <= ex_wdata_i;
            end
        end
    end

    assign waddr_a_o         = waddr_a_reg;
    assign wdata_a_o         = wdata_a_reg;
    assign we_a_o            = we_a_reg;
    assign waddr_b_o         = waddr_b_reg;
    assign wdata_b_o         = wdata_b_reg;
    assign we_b_o            = we_b_reg;
    assign spurious_rvalid_o = spurious_reg;

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Bench for riscv_wb_scoreboard: directed scenarios plus randomized traffic.
// The randomized traffic is checked against a queue-based reference model.
module tb_riscv_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_load_valid_i = 1'b0;
    logic [4:0]  issue_load_rd_i = '0;
    logic        issue_load_ready_o;
    logic        lsu_rvalid_i = 1'b0;
    logic [31:0] lsu_rdata_i = '0;
    logic        ex_valid_i = 1'b0;
    logic [4:0]  ex_rd_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        ex_ready_o;
    logic [4:0]  raddr_a_i = '0, raddr_b_i = '0, raddr_c_i = '0;
    logic        hazard_o;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic        we_a_o, we_b_o, spurious_rvalid_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_wb_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_load_valid_i(issue_load_valid_i), .issue_load_rd_i(issue_load_rd_i),
        .issue_load_ready_o(issue_load_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i), .hazard_o(hazard_o),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .spurious_rvalid_o(spurious_rvalid_o)
    );

    always #5 clk = ~clk;

    // Reference model. A register is busy while a load to it is still queued,
    // and also during the cycle in which its load data is being written back.
    logic [4:0]  m_q[$];
    logic        m_we_a = 1'b0, m_we_b = 1'b0, m_spur = 1'b0;
    logic [4:0]  m_waddr_a = '0, m_waddr_b = '0;
    logic [31:0] m_wdata_a = '0, m_wdata_b = '0;

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return m_we_b && (m_waddr_b == r);
    endfunction

    function automatic bit m_issue_ready(input logic [4:0] r);
        return (m_q.size() < 4) && !m_busy(r);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_we_a = 1'b0; m_we_b = 1'b0; m_spur = 1'b0;
        m_waddr_a = '0; m_waddr_b = '0; m_wdata_a = '0; m_wdata_b = '0;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // and settle 1 time unit past the edge.
    task automatic tick();
        bit ld_acc, ex_acc;
        logic [4:0] rd;
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else begin
            ld_acc = issue_load_valid_i && m_issue_ready(issue_load_rd_i);
            ex_acc = ex_valid_i && !m_busy(ex_rd_i);
            m_we_b = 1'b0;
            m_spur = 1'b0;
            if (lsu_rvalid_i) begin
                if (m_q.size() > 0) begin
                    rd = m_q.pop_front();
                    m_we_b = (rd != 5'd0); m_waddr_b = rd; m_wdata_b = lsu_rdata_i;
                end else begin
                    m_spur = 1'b1;
                end
            end
            if (ld_acc) m_q.push_back(issue_load_rd_i);
            m_we_a = 1'b0;
            if (ex_acc) begin
                m_we_a = (ex_rd_i != 5'd0); m_waddr_a = ex_rd_i; m_wdata_a = ex_wdata_i;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++; if ({we_a_o, we_b_o, spurious_rvalid_o} !== 3'b000) begin n_errors++; $display("FAIL reset_we: got %b required 000", {we_a_o, we_b_o, spurious_rvalid_o}); end
        n_checks++; if ({waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o} !== 74'd0) begin n_errors++; $display("FAIL reset_data: got %h required 0", {waddr_a_o, waddr_b_o, wdata_a_o, wdata_b_o}); end
        #2 rst_n = 1'b1;
        #1;
        n_checks++; if ({issue_load_ready_o, ex_ready_o, hazard_o} !== 3'b110) begin n_errors++; $display("FAIL reset_ready: got %b required 110", {issue_load_ready_o, ex_ready_o, hazard_o}); end
        $display("reset released");
    endtask

    task automatic test_single_load();
        raddr_a_i = 5'd5;
        issue_load_valid_i = 1'b1; issue_load_rd_i = 5'd5;
        #1;
        n_checks++; if (issue_load_ready_o !== 1'b1) begin n_errors++; $display("FAIL load_ready: got %b required 1", issue_load_ready_o); end
        tick();
        issue_load_valid_i = 1'b0;
        #1;
        n_checks++; if (hazard_o !== 1'b1) begin n_errors++; $display("FAIL load_hazard_pending: got %b required 1", hazard_o); end
        tick(); tick();
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hDEADBEEF;
        tick();
        lsu_rvalid_i = 1'b0;
        #1;
        n_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_errors++; $display("FAIL load_write: got we=%b addr=%0d data=%h required we=1 addr=5 data=deadbeef", we_b_o, waddr_b_o, wdata_b_o); end
        n_checks++; if (hazard_o !== 1'b1) begin n_errors++; $display("FAIL load_hazard_wb_cycle: got %b required 1", hazard_o); end
        tick();
        n_checks++; if ({we_b_o, hazard_o, waddr_b_o} !== {1'b0, 1'b0, 5'd5}) begin n_errors++; $display("FAIL load_after_wb: got we=%b hazard=%b addr=%0d required 0 0 5", we_b_o, hazard_o, waddr_b_o); end
        raddr_a_i = 5'd0;
        $display("load rd=5 data=deadbeef written back");
    endtask

    task automatic test_ex_stall();
        issue_load_valid_i = 1'b1; issue_load_rd_i = 5'd5;
        tick();
        issue_load_valid_i = 1'b0;
        ex_valid_i = 1'b1; ex_rd_i = 5'd5; ex_wdata_i = 32'h12345678;
        #1;
        n_checks++; if (ex_ready_o !== 1'b0) begin n_errors++; $display("FAIL ex_stall_pending: got %b required 0", ex_ready_o); end
        tick();
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0BADF00D;
        tick();
        lsu_rvalid_i = 1'b0;
        #1;
        n_checks++; if ({we_b_o, ex_ready_o, we_a_o} !== 3'b100) begin n_errors++; $display("FAIL ex_stall_wb_cycle: got we_b=%b ex_ready=%b we_a=%b required 1 0 0", we_b_o, ex_ready_o, we_a_o); end
        tick();
        n_checks++; if ({ex_ready_o, we_a_o} !== 2'b10) begin n_errors++; $display("FAIL ex_ready_after_wb: got ex_ready=%b we_a=%b required 1 0", ex_ready_o, we_a_o); end
        tick();
        ex_valid_i = 1'b0;
        #1;
        n_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {1'b1, 5'd5, 32'h12345678}) begin n_errors++; $display("FAIL ex_write: got we=%b addr=%0d data=%h required 1 5 12345678", we_a_o, waddr_a_o, wdata_a_o); end
        tick();
        n_checks++; if (we_a_o !== 1'b0) begin n_errors++; $display("FAIL ex_we_pulse: got %b required 0", we_a_o); end
        $display("ex rd=5 data=12345678 written after load");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            issue_load_valid_i = 1'b1; issue_load_rd_i = 5'(i);
            #1;
            n_checks++; if (issue_load_ready_o !== 1'b1) begin n_errors++; $display("FAIL b2b_issue_ready rd=%0d: got %b required 1", i, issue_load_ready_o); end
            tick();
        end
        issue_load_rd_i = 5'd9;
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'd101;
        #1;
        n_checks++; if (issue_load_ready_o !== 1'b0) begin n_errors++; $display("FAIL b2b_full_stall: got %b required 0", issue_load_ready_o); end
        tick();
        issue_load_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                lsu_rdata_i = 32'(100 + i);
                tick();
            end
            n_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== {1'b1, 5'(i), 32'(100 + i)}) begin n_errors++; $display("FAIL b2b_write %0d: got we=%b addr=%0d data=%0d required 1 %0d %0d", i, we_b_o, waddr_b_o, wdata_b_o, i, 100 + i); end
            $display("b2b load rd=%0d data=%0d", waddr_b_o, wdata_b_o);
        end
        lsu_rvalid_i = 1'b0;
        tick();
        n_checks++; if ({we_b_o, issue_load_ready_o} !== 2'b01) begin n_errors++; $display("FAIL b2b_drained: got we_b=%b ready=%b required 0 1", we_b_o, issue_load_ready_o); end
    endtask

    task automatic test_spurious_x0();
        lsu_rvalid_i = 1'b1;
        tick();
        lsu_rvalid_i = 1'b0;
        n_checks++; if ({spurious_rvalid_o, we_b_o} !== 2'b10) begin n_errors++; $display("FAIL spurious_pulse: got spur=%b we_b=%b required 1 0", spurious_rvalid_o, we_b_o); end
        tick();
        n_checks++; if (spurious_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL spurious_one_cycle: got %b required 0", spurious_rvalid_o); end
        issue_load_valid_i = 1'b1; issue_load_rd_i = 5'd0;
        raddr_a_i = 5'd0; ex_rd_i = 5'd0;
        tick();
        issue_load_valid_i = 1'b0;
        #1;
        n_checks++; if ({hazard_o, ex_ready_o} !== 2'b01) begin n_errors++; $display("FAIL x0_not_busy: got hazard=%b ex_ready=%b required 0 1", hazard_o, ex_ready_o); end
        lsu_rvalid_i = 1'b1;
        tick();
        n_checks++; if ({we_b_o, spurious_rvalid_o} !== 2'b00) begin n_errors++; $display("FAIL x0_response: got we_b=%b spur=%b required 0 0", we_b_o, spurious_rvalid_o); end
        tick();
        lsu_rvalid_i = 1'b0;
        n_checks++; if (spurious_rvalid_o !== 1'b1) begin n_errors++; $display("FAIL x0_entry_consumed: got %b required 1", spurious_rvalid_o); end
        tick();
        $display("spurious and x0 load handled");
    endtask

    task automatic test_reset_midflight();
        issue_load_valid_i = 1'b1; issue_load_rd_i = 5'd6;
        tick();
        issue_load_rd_i = 5'd7;
        tick();
        issue_load_valid_i = 1'b0;
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h66;
        tick();
        n_checks++; if ({we_b_o, waddr_b_o} !== {1'b1, 5'd6}) begin n_errors++; $display("FAIL mid_write: got we=%b addr=%0d required 1 6", we_b_o, waddr_b_o); end
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++; if ({we_b_o, waddr_b_o, wdata_b_o} !== 38'd0) begin n_errors++; $display("FAIL mid_async_clear: got we=%b addr=%0d data=%h required 0", we_b_o, waddr_b_o, wdata_b_o); end
        lsu_rvalid_i = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        raddr_a_i = 5'd7;
        #1;
        n_checks++; if ({issue_load_ready_o, hazard_o} !== 2'b10) begin n_errors++; $display("FAIL mid_after_reset: got ready=%b hazard=%b required 1 0", issue_load_ready_o, hazard_o); end
        lsu_rvalid_i = 1'b1;
        tick();
        lsu_rvalid_i = 1'b0;
        n_checks++; if ({spurious_rvalid_o, we_b_o} !== 2'b10) begin n_errors++; $display("FAIL mid_count_zero: got spur=%b we_b=%b required 1 0", spurious_rvalid_o, we_b_o); end
        raddr_a_i = 5'd0;
        $display("reset mid-response cleared state");
    endtask

    task automatic test_random();
        bit e_ir, e_er, e_hz;
        for (int c = 0; c < 400; c++) begin
            issue_load_valid_i = ($urandom_range(0, 1) == 1);
            issue_load_rd_i    = 5'($urandom_range(0, 7));
            lsu_rvalid_i       = ($urandom_range(0, 9) < 4);
            lsu_rdata_i        = $urandom;
            ex_valid_i         = ($urandom_range(0, 1) == 1);
            ex_rd_i            = 5'($urandom_range(0, 7));
            ex_wdata_i         = $urandom;
            raddr_a_i          = 5'($urandom_range(0, 7));
            raddr_b_i          = 5'($urandom_range(0, 7));
            raddr_c_i          = 5'($urandom_range(0, 7));
            #1;
            e_ir = m_issue_ready(issue_load_rd_i);
            e_er = !m_busy(ex_rd_i);
            e_hz = m_busy(raddr_a_i) || m_busy(raddr_b_i) || m_busy(raddr_c_i);
            n_checks++; if ({issue_load_ready_o, ex_ready_o, hazard_o} !== {e_ir, e_er, e_hz}) begin n_errors++; $display("FAIL rand_comb cyc=%0d: got ready/ex/hz=%b required %b", c, {issue_load_ready_o, ex_ready_o, hazard_o}, {e_ir, e_er, e_hz}); end
            tick();
            n_checks++; if ({we_a_o, waddr_a_o, wdata_a_o} !== {m_we_a, m_waddr_a, m_wdata_a}) begin n_errors++; $display("FAIL rand_port_a cyc=%0d: got %b/%0d/%h required %b/%0d/%h", c, we_a_o, waddr_a_o, wdata_a_o, m_we_a, m_waddr_a, m_wdata_a); end
            n_checks++; if ({we_b_o, waddr_b_o, wdata_b_o, spurious_rvalid_o} !== {m_we_b, m_waddr_b, m_wdata_b, m_spur}) begin n_errors++; $display("FAIL rand_port_b cyc=%0d: got %b/%0d/%h spur=%b required %b/%0d/%h spur=%b", c, we_b_o, waddr_b_o, wdata_b_o, spurious_rvalid_o, m_we_b, m_waddr_b, m_wdata_b, m_spur); end
            if (m_we_a || m_we_b) $display("rand cyc=%0d we_a=%b a=%0d we_b=%b b=%0d outstanding=%0d", c, m_we_a, m_waddr_a, m_we_b, m_waddr_b, m_q.size());
        end
        issue_load_valid_i = 1'b0; lsu_rvalid_i = 1'b0; ex_valid_i = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single_load();
        test_ex_stall();
        test_back_to_back();
        test_spurious_x0();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
